bsg_two_fifo_mem_ctrl: RTL and testbench
========================================

Name: bsg_two_fifo_mem_ctrl

Overview:
- Controller that owns both ports of a 2-entry, 1-read/1-write synthesized memory with read_write_same_addr_p0 semantics. The memory has a synchronous write and a combinational read.
- Turns a producer ready/valid stream and a consumer valid/yumi stream into memory write strobes and read addresses, giving a 2-deep FIFO.
- Sits between the memory instance and the surrounding pipeline. It is the write-side driver and read-address source the memory itself does not contain.

Parameters:
- width_p, 30, data width in bits; must match the memory width.
- els_p, 2, entry count; fixed at 2 (1-bit pointers). Any other value is an elaboration error.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  producer valid.
- data_i  in  width_p  producer data.
- ready_o  out  1  controller can accept data_i this cycle.
- v_o  out  1  head entry valid.
- data_o  out  width_p  head entry data, equal to mem_r_data_i.
- yumi_i  in  1  consumer takes the head this cycle; legal only when v_o=1.
- mem_w_v_o  out  1  memory write enable.
- mem_w_addr_o  out  1  memory write address.
- mem_w_data_o  out  width_p  memory write data, equal to data_i.
- mem_r_v_o  out  1  memory read enable, equal to v_o.
- mem_r_addr_o  out  1  memory read address.
- mem_r_data_i  in  width_p  memory combinational read data.
- count_o  out  2  occupancy, 0..2.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - wptr_r and rptr_r, 1 bit each.
  - count_r, 2 bits.
  - err_r, 1 bit.
- Reset (reset_n_i=0, asynchronous): wptr_r=0, rptr_r=0, count_r=0, err_r=0.
- Outputs while in reset:
  - ready_o=1 and v_o=0.
  - mem_w_v_o is forced to 0, gated combinationally by reset_n_i, so no write can reach the memory during reset.
- Control:
  - enq = v_i & ready_o & reset_n_i.
  - deq = yumi_i & v_o.
  - ready_o = (count_r != 2).
  - v_o = (count_r != 0).
- Memory drive:
  - mem_w_v_o = enq, mem_w_addr_o = wptr_r, mem_w_data_o = data_i.
  - mem_r_addr_o = rptr_r, mem_r_v_o = v_o, data_o = mem_r_data_i.
- Pointer and count updates per clock:
  - wptr_r toggles on enq; rptr_r toggles on deq.
  - count_r changes by +1 on enq only, -1 on deq only, and is unchanged on both or neither.
- Latency: data accepted in cycle t appears on data_o with v_o=1 in cycle t+1. There is no bypass, so an empty FIFO never presents data_i in the same cycle.
- Throughput: one enq and one deq per cycle when count_r=1. Sustained 1 item/cycle streaming is supported.
- Full (count_r=2): ready_o=0 even if yumi_i=1 that cycle. This guarantees mem_w_addr_o never equals the address being read when mem_w_v_o=1 (same-address read/write is forbidden).
- Empty (count_r=0):
  - v_o=0 and data_o is don't-care.
  - yumi_i=1 is ignored: no pointer or count change.
  - yumi_i=1 sets err_r=1.
- err_o = err_r; it stays set until reset.
- Pointer wrap: 1-bit pointers wrap 1 to 0 naturally; order is preserved across the wrap.
- Reset mid-operation: contents are abandoned, count_o=0 immediately (asynchronous), and memory contents are left stale but unreachable.
- count_o = count_r.
- Assertions (simulation only):
  - count_r never equals 3.
  - mem_w_v_o & (mem_w_addr_o==mem_r_addr_o) & v_o never holds.

Test Plan:
- Reset then idle: reset_n_i=0 mid-cycle -> count_o=0, v_o=0, ready_o=1, mem_w_v_o=0 immediately; release, 5 idle cycles -> unchanged.
- Fill to full: v_i=1 with data 0x0000_0AAA then 0x0000_0555, yumi_i=0 -> writes hit addr 0 then 1; count_o=2, ready_o=0; a third v_i=1 produces no write.
- Drain order: from full, yumi_i=1 for 2 cycles -> data_o=0x0AAA then 0x555, mem_r_addr_o 0 then 1, then v_o=0, count_o=0.
- Streaming across wrap: count=1, then v_i=1 and yumi_i=1 for 6 cycles with data 1..6 -> count_o stays 1, each value appears on data_o one cycle after acceptance, and write/read addresses always differ.
- Full with simultaneous yumi: count=2, v_i=1, yumi_i=1 -> no write (ready_o=0), one dequeue, count_o=1 next cycle.
- Underflow: count=0, yumi_i=1 -> pointers unchanged, err_o=1 next cycle and held; reset_n_i=0 -> err_o=0.

Source files
------------

// File: rtl/bsg_two_fifo_mem_ctrl_if.sv
// Bundle of the stream and memory-side signals around the 2-entry FIFO controller.
// Latency: none (wires only).
// Backpressure: carries ready_o (producer side) and yumi_i (consumer side).
//
// Signals: producer v_i/data_i/ready_o, consumer v_o/data_o/yumi_i,
// memory write port mem_w_*, memory read port mem_r_*, status count_o/err_o.
// Modport slave is the controller view; modport master is the surrounding logic.
interface bsg_two_fifo_mem_ctrl_if #(
    parameter int width_p = 30
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               mem_w_v_o;
    logic               mem_w_addr_o;
    logic [width_p-1:0] mem_w_data_o;
    logic               mem_r_v_o;
    logic               mem_r_addr_o;
    logic [width_p-1:0] mem_r_data_i;
    logic [1:0]         count_o;
    logic               err_o;

    modport slave (
        input  v_i, data_i, yumi_i, mem_r_data_i,
        output ready_o, v_o, data_o, mem_w_v_o, mem_w_addr_o, mem_w_data_o,
               mem_r_v_o, mem_r_addr_o, count_o, err_o
    );

    modport master (
        output v_i, data_i, yumi_i, mem_r_data_i,
        input  ready_o, v_o, data_o, mem_w_v_o, mem_w_addr_o, mem_w_data_o,
               mem_r_v_o, mem_r_addr_o, count_o, err_o
    );
endinterface

// File: rtl/bsg_two_fifo_mem_ctrl.sv
// Controller turning ready/valid in and valid/yumi out into a 2-deep FIFO over an external 1R1W memory.
// Latency: data accepted in cycle t is presented on data_o in cycle t+1 (no bypass).
// Backpressure: ready_o drops when full, even if the head is being taken that cycle.
//
// Ports: clk_i (rising-edge clock), reset_n_i (async active-low reset),
// bus (slave modport): producer/consumer handshakes, memory write strobe/address/data,
// memory read enable/address, combinational read data return, occupancy and sticky error.
module bsg_two_fifo_mem_ctrl #(
    parameter int width_p = 30,
    parameter int els_p   = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bsg_two_fifo_mem_ctrl_if.slave bus
);
    // Pointers are a single bit, so only a 2-entry memory is addressable.
    if (els_p != 2) begin : g_bad_els
        $error("bsg_two_fifo_mem_ctrl: els_p must be 2");
    end
    if (width_p < 1) begin : g_bad_width
        $error("bsg_two_fifo_mem_ctrl: width_p must be positive");
    end

    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] count_q, count_d;
    logic       err_q, err_d;

    logic ready;
    logic valid;
    logic enq;
    logic deq;

    always_comb begin
        ready   = (count_q != 2'd2);
        valid   = (count_q != 2'd0);
        // reset_n_i in the term keeps the write strobe dead while reset is held.
        enq     = bus.v_i & ready & reset_n_i;
        deq     = bus.yumi_i & valid;

        wptr_d  = wptr_q ^ enq;
        rptr_d  = rptr_q ^ deq;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // A yumi against an empty FIFO is a consumer protocol violation; latch it.
        err_d   = err_q | (bus.yumi_i & ~valid);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.v_o          = valid;
    assign bus.data_o       = bus.mem_r_data_i;
    assign bus.mem_w_v_o    = enq;
    assign bus.mem_w_addr_o = wptr_q;
    assign bus.mem_w_data_o = bus.data_i;
    assign bus.mem_r_v_o    = valid;
    assign bus.mem_r_addr_o = rptr_q;
    assign bus.count_o      = count_q;
    assign bus.err_o        = err_q;

    a_count_range : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_q != 2'd3);
    // Refusing writes when full is what keeps this from ever firing.
    a_no_same_addr : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enq && (wptr_q == rptr_q) && valid));
endmodule

// File: tb/tb_bsg_two_fifo_mem_ctrl.sv
module tb_bsg_two_fifo_mem_ctrl;
    localparam int W = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_two_fifo_mem_ctrl_if #(.width_p(W)) bus ();

    bsg_two_fifo_mem_ctrl #(.width_p(W), .els_p(2)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus.slave)
    );

    // External 2-entry memory: synchronous write, combinational read.
    logic [W-1:0] mem [2];
    always @(posedge clk) begin
        if (bus.mem_w_v_o) mem[bus.mem_w_addr_o] <= bus.mem_w_data_o;
    end
    assign bus.mem_r_data_i = mem[bus.mem_r_addr_o];

    int errs   = 0;
    int checks = 0;
    logic [W-1:0] sbq [$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         y;
        logic         rdy;
        logic         vo;
        logic [1:0]   cnt;
        logic         wv;
        logic         wa;
        logic         ra;
        logic         err;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and run the scoreboard before the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y);
        logic [W-1:0] exp;
        @(negedge clk);
        bus.v_i    = v;
        bus.data_i = d;
        bus.yumi_i = y;
        #1;
        if (y && bus.v_o) begin
            if (sbq.size() == 0) begin
                chk("deq_with_empty_scoreboard", 32'd1, 32'd0);
            end else begin
                exp = sbq.pop_front();
                chk("data_o", 32'(bus.data_o), 32'(exp));
            end
        end
        if (v && bus.ready_o) sbq.push_back(d);
    endtask

    function automatic vec_t mk(logic v, logic [W-1:0] d, logic y, logic rdy, logic vo,
                                logic [1:0] cnt, logic wv, logic wa, logic ra, logic err);
        vec_t r;
        r.v = v; r.d = d; r.y = y; r.rdy = rdy; r.vo = vo;
        r.cnt = cnt; r.wv = wv; r.wa = wa; r.ra = ra; r.err = err;
        return r;
    endfunction

    initial begin
        //          v  data      y  rdy vo cnt  wv wa ra err
        tbl[0]  = mk(0, 30'h0,   0, 1,  0, 2'd0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 30'hAAA, 0, 1,  0, 2'd0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 30'h555, 0, 1,  1, 2'd1, 1, 1, 0, 0);
        tbl[3]  = mk(1, 30'h777, 0, 0,  1, 2'd2, 0, 0, 0, 0);
        tbl[4]  = mk(0, 30'h0,   1, 0,  1, 2'd2, 0, 0, 0, 0);
        tbl[5]  = mk(0, 30'h0,   1, 1,  1, 2'd1, 0, 0, 1, 0);
        tbl[6]  = mk(0, 30'h0,   0, 1,  0, 2'd0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 30'h10,  0, 1,  0, 2'd0, 1, 0, 0, 0);
        tbl[8]  = mk(1, 30'h1,   1, 1,  1, 2'd1, 1, 1, 0, 0);
        tbl[9]  = mk(1, 30'h2,   1, 1,  1, 2'd1, 1, 0, 1, 0);
        tbl[10] = mk(1, 30'h3,   1, 1,  1, 2'd1, 1, 1, 0, 0);
        tbl[11] = mk(1, 30'h4,   1, 1,  1, 2'd1, 1, 0, 1, 0);
        tbl[12] = mk(1, 30'h5,   1, 1,  1, 2'd1, 1, 1, 0, 0);
        tbl[13] = mk(1, 30'h6,   1, 1,  1, 2'd1, 1, 0, 1, 0);
        tbl[14] = mk(1, 30'h20,  0, 1,  1, 2'd1, 1, 1, 0, 0);
        tbl[15] = mk(1, 30'h30,  1, 0,  1, 2'd2, 0, 0, 0, 0);
        tbl[16] = mk(0, 30'h0,   1, 1,  1, 2'd1, 0, 0, 1, 0);
        tbl[17] = mk(0, 30'h0,   1, 1,  0, 2'd0, 0, 0, 0, 0);
        tbl[18] = mk(0, 30'h0,   0, 1,  0, 2'd0, 0, 0, 0, 1);
        tbl[19] = mk(0, 30'h0,   0, 1,  0, 2'd0, 0, 0, 0, 1);

        bus.v_i = 1'b0;
        bus.data_i = '0;
        bus.yumi_i = 1'b0;

        // Power-up reset, then put one entry in so the mid-cycle reset has state to clear.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1, 30'h123, 0);
        step(1, 30'h124, 0);
        chk("pre_reset_count", 32'(bus.count_o), 32'd1);

        // Asynchronous reset mid-cycle with a write being offered.
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_v_o", 32'(bus.v_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_mem_w_v", 32'(bus.mem_w_v_o), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_mem_w_v", 32'(bus.mem_w_v_o), 32'd0);
        bus.v_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(0, 30'h0, 0);
            chk($sformatf("idle%0d_count", i), 32'(bus.count_o), 32'd0);
            chk($sformatf("idle%0d_v_o", i), 32'(bus.v_o), 32'd0);
            chk($sformatf("idle%0d_ready", i), 32'(bus.ready_o), 32'd1);
        end

        // Fill, drain, stream across wrap, full+yumi, underflow.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].y);
            chk($sformatf("row%0d_ready", i), 32'(bus.ready_o), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_v_o", i), 32'(bus.v_o), 32'(tbl[i].vo));
            chk($sformatf("row%0d_mem_r_v", i), 32'(bus.mem_r_v_o), 32'(tbl[i].vo));
            chk($sformatf("row%0d_count", i), 32'(bus.count_o), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_mem_w_v", i), 32'(bus.mem_w_v_o), 32'(tbl[i].wv));
            chk($sformatf("row%0d_w_addr", i), 32'(bus.mem_w_addr_o), 32'(tbl[i].wa));
            chk($sformatf("row%0d_r_addr", i), 32'(bus.mem_r_addr_o), 32'(tbl[i].ra));
            chk($sformatf("row%0d_err", i), 32'(bus.err_o), 32'(tbl[i].err));
            chk($sformatf("row%0d_w_data", i), 32'(bus.mem_w_data_o), 32'(tbl[i].d));
        end
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        // Sticky error cleared only by reset.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("err_cleared_by_reset", 32'(bus.err_o), 32'd0);
        chk("err_reset_count", 32'(bus.count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
